pre_ready_tracker: RTL and testbench

Per-bank open/closed state and precharge-eligibility tracker for the command scheduler. It sits directly downstream of the tRAS counter and consumes its per-bank `o_ras_counter` vector alongside the same issued-command bus. It merges tRAS with its own read-to-precharge (tRTP) and write-recovery (tWRP) counters to produce per-bank and per-rank precharge-ready vectors. It also flags illegal commands.

---
 rtl/pre_ready_tracker.sv | 137 +++++++++++++
 tb/tb_pre_ready_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pre_ready_tracker.sv
// pre_ready_tracker: per-bank open/closed tracking, tRTP/tWR precharge eligibility and illegal-command flagging
module pre_ready_tracker #(
    parameter int CMD_TYPE_WIDTH = 3,
    parameter int NUM_RNK = 1,
    parameter int NUM_BG = 2,
    parameter int NUM_BNK = 4,
    parameter int NUM_BNK_TOT = NUM_RNK * NUM_BG * NUM_BNK,
    parameter int RNK_SEL_WIDTH = 1,
    parameter int BG_SEL_WIDTH = 1,
    parameter int BNK_SEL_WIDTH = 2,
    parameter int TIME_WIDTH = 6,
    parameter int ISSUED_SUB_CYCLE = 3,
    parameter int T_RTP = 8,
    parameter int T_WRP = 30,
    parameter logic [CMD_TYPE_WIDTH-1:0] CMD_ACT = 1,
    parameter logic [CMD_TYPE_WIDTH-1:0] CMD_PRE = 2,
    parameter logic [CMD_TYPE_WIDTH-1:0] CMD_PREA = 3,
    parameter logic [CMD_TYPE_WIDTH-1:0] CMD_RD = 4,
    parameter logic [CMD_TYPE_WIDTH-1:0] CMD_WR = 5
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [CMD_TYPE_WIDTH-1:0]         i_cmd_type,
    input  logic [RNK_SEL_WIDTH-1:0]          i_cmd_rnk,
    input  logic [BG_SEL_WIDTH-1:0]           i_cmd_bg,
    input  logic [BNK_SEL_WIDTH-1:0]          i_cmd_bnk,
    input  logic [NUM_BNK_TOT*TIME_WIDTH-1:0] i_ras_counter,
    output logic [NUM_BNK_TOT-1:0]            o_bank_open,
    output logic [NUM_BNK_TOT-1:0]            o_pre_ready,
    output logic [NUM_RNK-1:0]                o_prea_ready,
    output logic                              o_err_illegal
);
    // Sub-cycles between the issued sub-slot and the next clock edge
    localparam int OFFSET = (ISSUED_SUB_CYCLE >= 0 && ISSUED_SUB_CYCLE <= 3) ? 4 - ISSUED_SUB_CYCLE : 0;
    localparam int BNK_PER_RNK = NUM_BG * NUM_BNK;
    localparam logic [TIME_WIDTH-1:0] STEP = TIME_WIDTH'(4);
    localparam logic [TIME_WIDTH-1:0] RTP_LOAD = TIME_WIDTH'(T_RTP - OFFSET);
    localparam logic [TIME_WIDTH-1:0] WRP_LOAD = TIME_WIDTH'(T_WRP - OFFSET);

    typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} bank_state_t;

    logic [NUM_BNK_TOT-1:0] bank_illegal;
    logic                   tgt_ok;
    logic                   rnk_ok;
    int                     tgt;
    logic                   err_q;

    function automatic logic [TIME_WIDTH-1:0] dec(input logic [TIME_WIDTH-1:0] x);
        return (x > STEP) ? x - STEP : '0;
    endfunction

    function automatic logic [TIME_WIDTH-1:0] max_t(input logic [TIME_WIDTH-1:0] a, input logic [TIME_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign rnk_ok = int'(i_cmd_rnk) < NUM_RNK;
    assign tgt_ok = rnk_ok && int'(i_cmd_bg) < NUM_BG && int'(i_cmd_bnk) < NUM_BNK;
    assign tgt = int'(i_cmd_rnk) * BNK_PER_RNK + int'(i_cmd_bg) * NUM_BNK + int'(i_cmd_bnk);

    for (genvar r = 0; r < NUM_RNK; r++) begin : g_rnk
        assign o_prea_ready[r] = &(~o_bank_open[r*BNK_PER_RNK +: BNK_PER_RNK] | o_pre_ready[r*BNK_PER_RNK +: BNK_PER_RNK]);
    end

    for (genvar g = 0; g < NUM_BNK_TOT; g++) begin : g_bank
        localparam int R = g / BNK_PER_RNK;
        bank_state_t           state_q;
        bank_state_t           state_d;
        logic [TIME_WIDTH-1:0] rtp_q;
        logic [TIME_WIDTH-1:0] rtp_d;
        logic [TIME_WIDTH-1:0] wrp_q;
        logic [TIME_WIDTH-1:0] wrp_d;
        logic                  hit;
        logic                  in_rnk;
        logic                  ill;

        assign hit = tgt_ok && tgt == g;
        assign in_rnk = rnk_ok && int'(i_cmd_rnk) == R;
        assign o_bank_open[g] = state_q == OPEN;
        assign o_pre_ready[g] = state_q == OPEN && i_ras_counter[g*TIME_WIDTH +: TIME_WIDTH] == '0 && rtp_q == '0 && wrp_q == '0;
        assign bank_illegal[g] = ill;

        // Next state: judge legality on current outputs, otherwise just age the counters
        always_comb begin
            state_d = state_q;
            rtp_d = dec(rtp_q);
            wrp_d = dec(wrp_q);
            ill = 1'b0;
            if (hit && i_cmd_type == CMD_ACT) begin
                if (state_q == OPEN) ill = 1'b1;
                else begin
                    state_d = OPEN;
                    rtp_d = '0;
                    wrp_d = '0;
                end
            end else if (hit && i_cmd_type == CMD_PRE && state_q == OPEN) begin
                if (o_pre_ready[g]) begin
                    state_d = CLOSED;
                    rtp_d = '0;
                    wrp_d = '0;
                end else ill = 1'b1;
            end else if (in_rnk && i_cmd_type == CMD_PREA) begin
                if (o_prea_ready[R]) begin
                    state_d = CLOSED;
                    rtp_d = '0;
                    wrp_d = '0;
                end else ill = 1'b1;
            end else if (hit && i_cmd_type == CMD_RD) begin
                if (state_q == CLOSED) ill = 1'b1;
                else rtp_d = max_t(dec(rtp_q), RTP_LOAD);
            end else if (hit && i_cmd_type == CMD_WR) begin
                if (state_q == CLOSED) ill = 1'b1;
                else wrp_d = max_t(dec(wrp_q), WRP_LOAD);
            end
        end

        // Bank state and timing counters
        always_ff @(posedge i_clk) begin
            if (!i_rstn) begin
                state_q <= CLOSED;
                rtp_q <= '0;
                wrp_q <= '0;
            end else begin
                state_q <= state_d;
                rtp_q <= rtp_d;
                wrp_q <= wrp_d;
            end
        end
    end

    // Registered one-cycle illegal-command pulse
    always_ff @(posedge i_clk) begin
        if (!i_rstn) err_q <= 1'b0;
        else err_q <= |bank_illegal;
    end

    assign o_err_illegal = err_q;
endmodule

// File: tb/tb_pre_ready_tracker.sv
// tb_pre_ready_tracker: directed scenarios plus random traffic checked against a deadline-based model
module tb_pre_ready_tracker;
    localparam int TW = 6;
    localparam int NB = 8;
    localparam int ISC = 3;
    localparam int T_RTP = 8;
    localparam int T_WRP = 30;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, PRE = 3'd2, PREA = 3'd3, RD = 3'd4, WR = 3'd5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [2:0]       cmd = '0;
    logic [0:0]       rnk = '0;
    logic [0:0]       bg = '0;
    logic [1:0]       bnk = '0;
    logic [NB*TW-1:0] ras = '0;
    logic [NB-1:0]    bank_open;
    logic [NB-1:0]    pre_ready;
    logic [0:0]       prea_ready;
    logic             err_illegal;

    // Model: open flag and the absolute sub-cycle at which each bank's RD/WR restriction expires
    bit      m_open [NB];
    longint  rd_dl [NB];
    longint  wr_dl [NB];
    bit      m_err;
    longint  cyc = 0;
    int      nvec = 0;
    int      nerr = 0;

    always #5 clk = ~clk;

    pre_ready_tracker dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .i_cmd_type(cmd),
        .i_cmd_rnk(rnk),
        .i_cmd_bg(bg),
        .i_cmd_bnk(bnk),
        .i_ras_counter(ras),
        .o_bank_open(bank_open),
        .o_pre_ready(pre_ready),
        .o_prea_ready(prea_ready),
        .o_err_illegal(err_illegal)
    );

    function automatic logic [NB*TW-1:0] rv(input int b, input int v);
        logic [NB*TW-1:0] r;
        r = '0;
        r[b*TW +: TW] = TW'(v);
        return r;
    endfunction

    function automatic logic [NB-1:0] exp_open();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = m_open[b];
        return v;
    endfunction

    function automatic logic [NB-1:0] exp_pre();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++)
            v[b] = m_open[b] && ras[b*TW +: TW] == 0 && 4*cyc >= rd_dl[b] && 4*cyc >= wr_dl[b];
        return v;
    endfunction

    function automatic logic exp_prea();
        logic [NB-1:0] p;
        p = exp_pre();
        for (int b = 0; b < NB; b++) if (m_open[b] && !p[b]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input logic [2:0] c, input int b, input logic [NB*TW-1:0] ras_nx, input bit r_n);
        logic [NB-1:0] pr;
        logic pa;
        bit ill;
        cmd = c;
        rnk = b[3];
        bg = b[2];
        bnk = b[1:0];
        rstn = r_n;
        pr = exp_pre();
        pa = exp_prea();
        ill = 0;
        if (!r_n) begin
            for (int i = 0; i < NB; i++) begin
                m_open[i] = 0;
                rd_dl[i] = 0;
                wr_dl[i] = 0;
            end
        end else begin
            case (c)
                ACT: if (m_open[b]) ill = 1; else begin m_open[b] = 1; rd_dl[b] = 0; wr_dl[b] = 0; end
                PRE: if (m_open[b]) begin
                    if (pr[b]) begin m_open[b] = 0; rd_dl[b] = 0; wr_dl[b] = 0; end else ill = 1;
                end
                PREA: if (pa) begin
                    for (int i = 0; i < NB; i++) begin m_open[i] = 0; rd_dl[i] = 0; wr_dl[i] = 0; end
                end else ill = 1;
                RD: if (!m_open[b]) ill = 1; else if (4*cyc + ISC + T_RTP > rd_dl[b]) rd_dl[b] = 4*cyc + ISC + T_RTP;
                WR: if (!m_open[b]) ill = 1; else if (4*cyc + ISC + T_WRP > wr_dl[b]) wr_dl[b] = 4*cyc + ISC + T_WRP;
                default: ;
            endcase
        end
        m_err = r_n && ill;
        @(posedge clk);
        #1;
        cyc++;
        ras = ras_nx;
        #1;
    endtask

    task automatic test_reset();
        step(NOP, 0, '0, 0);
        for (int k = 0; k < 6; k++) begin
            nvec++;
            if (bank_open !== 8'h00) begin nerr++; $display("FAIL reset_open k=%0d got %b exp 00000000", k, bank_open); end
            nvec++;
            if (pre_ready !== 8'h00) begin nerr++; $display("FAIL reset_pre k=%0d got %b exp 00000000", k, pre_ready); end
            nvec++;
            if (prea_ready !== 1'b1) begin nerr++; $display("FAIL reset_prea k=%0d got %b exp 1", k, prea_ready); end
            nvec++;
            if (err_illegal !== 1'b0) begin nerr++; $display("FAIL reset_err k=%0d got %b exp 0", k, err_illegal); end
            if (k < 5) step(NOP, 0, '0, 1);
        end
    endtask

    task automatic test_act_ras();
        logic [NB*TW-1:0] seq [3];
        seq[0] = rv(3, 8);
        seq[1] = rv(3, 4);
        seq[2] = '0;
        for (int k = 0; k < 3; k++) begin
            step(k == 0 ? ACT : NOP, 3, seq[k], 1);
            nvec++;
            if (bank_open[3] !== 1'b1) begin nerr++; $display("FAIL act_open k=%0d got %b exp 1", k, bank_open[3]); end
            nvec++;
            if (pre_ready[3] !== (k == 2)) begin nerr++; $display("FAIL act_pre k=%0d got %b exp %b", k, pre_ready[3], k == 2); end
            nvec++;
            if (prea_ready !== (k == 2)) begin nerr++; $display("FAIL act_prea k=%0d got %b exp %b", k, prea_ready, k == 2); end
        end
    endtask

    task automatic test_wr_rd_pre();
        logic [2:0] c;
        for (int k = 0; k < 10; k++) begin
            c = k == 0 ? WR : k == 2 ? RD : k == 4 ? PRE : NOP;
            step(c, 3, '0, 1);
            nvec++;
            if (pre_ready[3] !== (k + 1 >= 9)) begin nerr++; $display("FAIL wr_pre cyc=N+%0d got %b exp %b", k + 1, pre_ready[3], k + 1 >= 9); end
            nvec++;
            if (err_illegal !== (k == 4)) begin nerr++; $display("FAIL wr_err cyc=N+%0d got %b exp %b", k + 1, err_illegal, k == 4); end
            nvec++;
            if (bank_open[3] !== 1'b1) begin nerr++; $display("FAIL wr_open cyc=N+%0d got %b exp 1", k + 1, bank_open[3]); end
        end
    endtask

    task automatic test_prea();
        step(ACT, 0, '0, 1);
        step(ACT, 5, '0, 1);
        nvec++;
        if (bank_open !== 8'b0010_1001) begin nerr++; $display("FAIL prea_pre_open got %b exp 00101001", bank_open); end
        nvec++;
        if (prea_ready !== 1'b1) begin nerr++; $display("FAIL prea_ready got %b exp 1", prea_ready); end
        step(PREA, 0, '0, 1);
        nvec++;
        if (bank_open !== 8'h00) begin nerr++; $display("FAIL prea_open got %b exp 00000000", bank_open); end
        nvec++;
        if (err_illegal !== 1'b0) begin nerr++; $display("FAIL prea_err got %b exp 0", err_illegal); end
    endtask

    task automatic test_illegal_reset();
        step(RD, 2, '0, 1);
        nvec++;
        if (err_illegal !== 1'b1) begin nerr++; $display("FAIL ill_rd_err got %b exp 1", err_illegal); end
        nvec++;
        if (bank_open !== 8'h00) begin nerr++; $display("FAIL ill_rd_open got %b exp 00000000", bank_open); end
        step(ACT, 1, '0, 1);
        nvec++;
        if (err_illegal !== 1'b0) begin nerr++; $display("FAIL ill_act1_err got %b exp 0", err_illegal); end
        step(ACT, 1, '0, 1);
        nvec++;
        if (err_illegal !== 1'b1) begin nerr++; $display("FAIL ill_act2_err got %b exp 1", err_illegal); end
        nvec++;
        if (bank_open !== 8'h02) begin nerr++; $display("FAIL ill_act2_open got %b exp 00000010", bank_open); end
        step(ACT, 4, '0, 0);
        nvec++;
        if (bank_open !== 8'h00) begin nerr++; $display("FAIL midrst_open got %b exp 00000000", bank_open); end
        nvec++;
        if (err_illegal !== 1'b0) begin nerr++; $display("FAIL midrst_err got %b exp 0", err_illegal); end
        nvec++;
        if (prea_ready !== 1'b1) begin nerr++; $display("FAIL midrst_prea got %b exp 1", prea_ready); end
        step(NOP, 0, '0, 1);
    endtask

    task automatic test_random();
        logic [NB*TW-1:0] rn;
        logic [2:0] c;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < NB; b++) rn[b*TW +: TW] = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(1, 20)) : '0;
            c = 3'($urandom_range(0, 7));
            step(c, int'($urandom_range(0, 7)), rn, $urandom_range(0, 99) != 0);
            nvec++;
            if (bank_open !== exp_open()) begin nerr++; $display("FAIL rnd_open k=%0d got %b exp %b", k, bank_open, exp_open()); end
            nvec++;
            if (pre_ready !== exp_pre()) begin nerr++; $display("FAIL rnd_pre k=%0d got %b exp %b", k, pre_ready, exp_pre()); end
            nvec++;
            if (prea_ready !== exp_prea()) begin nerr++; $display("FAIL rnd_prea k=%0d got %b exp %b", k, prea_ready, exp_prea()); end
            nvec++;
            if (err_illegal !== m_err) begin nerr++; $display("FAIL rnd_err k=%0d got %b exp %b", k, err_illegal, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_act_ras();
        test_wr_rd_pre();
        test_prea();
        test_illegal_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
